// File: rtl/shift_operand_queue.sv
// ---------------------------------------------------------------------------
// shift_operand_queue
//
// Issue-stage FIFO in front of the shifter. Requests (two operands, two shift
// amounts, opcode, mode) arrive over a valid/ready handshake, are buffered in
// a DEPTH-entry FIFO and the head entry is presented already formatted for
// the shifter inputs InA_Re/InA_Im/ShiftAmount_Re/ShiftAmount_Im/OpSel/mode.
// Opcodes other than SLL/SRL/SRA/ROL/ROR are accepted but dropped, and the
// sticky illegal_op flag records that it happened.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid / in_ready     request handshake (in_ready = count < DEPTH)
//   in_a_re, in_a_im        operands (DW bits)
//   in_sh_re, in_sh_im      shift amounts (SAW bits)
//   in_opsel, in_mode       opcode (5 bits), 0 = simple / 1 = complex math
//   out_valid / out_ready   head entry handshake toward the shifter
//   out_*                   formatted head entry (all zero when empty)
//   count                   current occupancy
//   illegal_op              sticky: a non-shift opcode was dropped
//
// Optional feature macro: SHIFT_QUEUE_BYPASS_EN
//   When defined, a legal request arriving at an empty queue is presented on
//   out_* in the same cycle; if consumed immediately it is never written.
// ---------------------------------------------------------------------------
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef SLL
`define SLL 5'd1
`endif
`ifndef SRL
`define SRL 5'd2
`endif
`ifndef SRA
`define SRA 5'd3
`endif
`ifndef ROL
`define ROL 5'd4
`endif
`ifndef ROR
`define ROR 5'd5
`endif

module shift_operand_queue #(
  parameter int DEPTH = 4,
  parameter int DW    = `DATA_WIDTH,
  parameter int SAW   = $clog2(`DATA_WIDTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DW-1:0]            in_a_re,
  input  logic [DW-1:0]            in_a_im,
  input  logic [SAW-1:0]           in_sh_re,
  input  logic [SAW-1:0]           in_sh_im,
  input  logic [4:0]               in_opsel,
  input  logic                     in_mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DW-1:0]            out_a_re,
  output logic [DW-1:0]            out_a_im,
  output logic [SAW-1:0]           out_sh_re,
  output logic [SAW-1:0]           out_sh_im,
  output logic [4:0]               out_opsel,
  output logic                     out_mode,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     illegal_op
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [DW-1:0]  a_re;
    logic [DW-1:0]  a_im;
    logic [SAW-1:0] sh_re;
    logic [SAW-1:0] sh_im;
    logic [4:0]     opsel;
    logic           mode;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            illegal_q, illegal_d;

  logic            legal_s;
  logic            accept_s;
  logic            bypass_s;
  logic            push_wr_s;
  logic            pop_mem_s;
  entry_t          wr_entry_s;
  entry_t          out_entry_s;

  // Opcode screen: only the five shift codes are allowed into the queue.
  always_comb begin
    legal_s = 1'b0;
    case (in_opsel)
      `SLL, `SRL, `SRA, `ROL, `ROR: legal_s = 1'b1;
      default:                      legal_s = 1'b0;
    endcase
  end

  // Handshake, write formatting, bypass decision and next-state logic.
  always_comb begin
    in_ready = (count_q < CW'(DEPTH));
    accept_s = in_valid & in_ready;

    // Complex mode uses one amount for both lanes, so the real amount is
    // copied into the imaginary slot at write time.
    wr_entry_s.a_re  = in_a_re;
    wr_entry_s.a_im  = in_a_im;
    wr_entry_s.sh_re = in_sh_re;
    wr_entry_s.sh_im = in_mode ? in_sh_re : in_sh_im;
    wr_entry_s.opsel = in_opsel;
    wr_entry_s.mode  = in_mode;

`ifdef SHIFT_QUEUE_BYPASS_EN
    bypass_s = (count_q == CW'(0)) & in_valid & legal_s;
`else
    bypass_s = 1'b0;
`endif

    // A bypassed request consumed in the same cycle never touches storage.
    push_wr_s = accept_s & legal_s & ~(bypass_s & out_ready);
    pop_mem_s = (count_q != CW'(0)) & out_ready;

    wr_ptr_d  = push_wr_s ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d  = pop_mem_s ? rd_ptr_q + PW'(1) : rd_ptr_q;

    case ({push_wr_s, pop_mem_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    illegal_d = illegal_q | (accept_s & ~legal_s);

    // Empty queue drives all zeros so the shifter falls into its default.
    if (count_q != CW'(0)) begin
      out_entry_s = mem_q[rd_ptr_q];
    end else if (bypass_s) begin
      out_entry_s = wr_entry_s;
    end else begin
      out_entry_s = '0;
    end

    out_valid  = (count_q != CW'(0)) | bypass_s;
    out_a_re   = out_entry_s.a_re;
    out_a_im   = out_entry_s.a_im;
    out_sh_re  = out_entry_s.sh_re;
    out_sh_im  = out_entry_s.sh_im;
    out_opsel  = out_entry_s.opsel;
    out_mode   = out_entry_s.mode;
    count      = count_q;
    illegal_op = illegal_q;
  end

  // Control state: pointers, occupancy and sticky illegal flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      illegal_q <= illegal_d;
    end
  end

  // Entry storage; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (push_wr_s) begin
      mem_q[wr_ptr_q] <= wr_entry_s;
    end
  end

endmodule

// File: tb/tb_shift_operand_queue.sv
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef SLL
`define SLL 5'd1
`endif
`ifndef SRL
`define SRL 5'd2
`endif
`ifndef SRA
`define SRA 5'd3
`endif
`ifndef ROL
`define ROL 5'd4
`endif
`ifndef ROR
`define ROR 5'd5
`endif

module tb_shift_operand_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a_re = 16'h0000;
  logic [15:0] in_a_im = 16'h0000;
  logic [3:0]  in_sh_re = 4'd0;
  logic [3:0]  in_sh_im = 4'd0;
  logic [4:0]  in_opsel = 5'd0;
  logic        in_mode = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_a_re;
  logic [15:0] out_a_im;
  logic [3:0]  out_sh_re;
  logic [3:0]  out_sh_im;
  logic [4:0]  out_opsel;
  logic        out_mode;
  logic [2:0]  count;
  logic        illegal_op;

  int vectors = 0;
  int miscompares = 0;

  // expected entry: {a_re, a_im, sh_re, sh_im, opsel, mode} = 46 bits
  logic [45:0] sb[$];

  shift_operand_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a_re(in_a_re), .in_a_im(in_a_im),
    .in_sh_re(in_sh_re), .in_sh_im(in_sh_im),
    .in_opsel(in_opsel), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a_re(out_a_re), .out_a_im(out_a_im),
    .out_sh_re(out_sh_re), .out_sh_im(out_sh_im),
    .out_opsel(out_opsel), .out_mode(out_mode),
    .count(count), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: every consumed head entry is compared against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_pop: got %0h expected none at %0t",
                 {out_a_re, out_a_im, out_sh_re, out_sh_im, out_opsel, out_mode}, $time);
      end else begin
        check("pop_data",
              {18'd0, out_a_re, out_a_im, out_sh_re, out_sh_im, out_opsel, out_mode},
              {18'd0, sb.pop_front()});
      end
    end
  end

  // Present one request; waits (bounded) for in_ready, returns #1 after the
  // accepting edge with in_valid dropped.
  task automatic push(input logic [15:0] are, input logic [15:0] aim,
                      input logic [3:0] shre, input logic [3:0] shim,
                      input logic [4:0] op, input logic md,
                      input logic [3:0] exp_shim, input bit legal);
    int guard = 0;
    in_a_re = are; in_a_im = aim; in_sh_re = shre; in_sh_im = shim;
    in_opsel = op; in_mode = md; in_valid = 1'b1;
    while (!in_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL push_timeout: got in_ready=0 expected 1 at %0t", $time);
    end else if (legal) begin
      sb.push_back({are, aim, shre, exp_shim, op, md});
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  logic [15:0] fill_a [4];

  initial begin
    fill_a[0] = 16'h1000; fill_a[1] = 16'h2001;
    fill_a[2] = 16'h3002; fill_a[3] = 16'h4003;

    // Reset state
    #2;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_count", {61'd0, count}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_illegal", {63'd0, illegal_op}, 64'd0);
    check("rst_out_data", {16'd0, out_a_re, out_a_im, out_opsel, out_sh_re, out_sh_im, 3'd0},
          64'd0);
    @(negedge clk); rst_n = 1'b1;
    cycles(1);

    // Single push, simple mode
    out_ready = 1'b1;
    push(16'h8001, 16'h1234, 4'd3, 4'd1, `SRA, 1'b0, 4'd1, 1'b1);
`ifndef SHIFT_QUEUE_BYPASS_EN
    check("single_out_valid", {63'd0, out_valid}, 64'd1);
    check("single_count1", {61'd0, count}, 64'd1);
    cycles(1);
`endif
    check("single_count0", {61'd0, count}, 64'd0);

    // Complex mode: imaginary amount follows the real amount
    push(16'h00F0, 16'h0F00, 4'd5, 4'd2, `ROL, 1'b1, 4'd5, 1'b1);
    cycles(2);

    // Fill with out_ready low, then a rejected 5th push, then drain
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      push(fill_a[i], 16'h0000, 4'(i), 4'(i + 8), `SLL, 1'b0, 4'(i + 8), 1'b1);
    check("full_count", {61'd0, count}, 64'd4);
    check("full_in_ready", {63'd0, in_ready}, 64'd0);
    in_a_re = 16'hDEAD; in_opsel = `SRL; in_valid = 1'b1;
    cycles(1);
    in_valid = 1'b0;
    check("full_reject_count", {61'd0, count}, 64'd4);
    check("full_hold_data", {48'd0, out_a_re}, 64'h1000);
    check("full_hold_valid", {63'd0, out_valid}, 64'd1);
    out_ready = 1'b1;
    cycles(5);
    check("drain_count", {61'd0, count}, 64'd0);

    // Simultaneous push/pop at count = 2
    out_ready = 1'b0;
    push(16'hA000, 16'h0001, 4'd1, 4'd2, `SRL, 1'b0, 4'd2, 1'b1);
    push(16'hA001, 16'h0002, 4'd3, 4'd4, `ROR, 1'b0, 4'd4, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push(16'hB000 + 16'(i), 16'h5555, 4'(i), 4'(15 - i), `SRA, 1'b0, 4'(15 - i), 1'b1);
      check("simul_count", {61'd0, count}, 64'd2);
    end
    cycles(3);
    check("simul_drain_count", {61'd0, count}, 64'd0);

    // Illegal opcode: handshake completes, nothing stored, sticky flag
    push(16'hBAD0, 16'hBAD1, 4'd1, 4'd1, 5'b11111, 1'b0, 4'd1, 1'b0);
    check("illegal_count", {61'd0, count}, 64'd0);
    check("illegal_flag", {63'd0, illegal_op}, 64'd1);
    check("illegal_no_valid", {63'd0, out_valid}, 64'd0);
    push(16'h0042, 16'h0043, 4'd2, 4'd3, `SLL, 1'b0, 4'd3, 1'b1);
    cycles(3);
    check("illegal_sticky", {63'd0, illegal_op}, 64'd1);

    // Asynchronous reset with three entries queued
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      push(16'hC000 + 16'(i), 16'h0000, 4'd1, 4'd1, `SRL, 1'b0, 4'd1, 1'b1);
    check("prerst_count", {61'd0, count}, 64'd3);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", {63'd0, out_valid}, 64'd0);
    check("async_rst_count", {61'd0, count}, 64'd0);
    check("async_rst_illegal", {63'd0, illegal_op}, 64'd0);
    sb.delete();
    @(negedge clk); rst_n = 1'b1;
    cycles(1);
    out_ready = 1'b1;
    push(16'h7777, 16'h8888, 4'd7, 4'd6, `ROR, 1'b0, 4'd6, 1'b1);
    cycles(2);

`ifdef SHIFT_QUEUE_BYPASS_EN
    // Zero-latency bypass at an empty queue
    in_a_re = 16'h5A5A; in_a_im = 16'hA5A5; in_sh_re = 4'd4; in_sh_im = 4'd9;
    in_opsel = `SLL; in_mode = 1'b0; in_valid = 1'b1;
    sb.push_back({16'h5A5A, 16'hA5A5, 4'd4, 4'd9, `SLL, 1'b0});
    #1;
    check("bypass_valid", {63'd0, out_valid}, 64'd1);
    check("bypass_count", {61'd0, count}, 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bypass_count_after", {61'd0, count}, 64'd0);
`endif

    cycles(2);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/shift_operand_queue.md
Name: shift_operand_queue

Overview:
- Upstream issue stage for the shifter. Accepts shift requests over a valid/ready handshake: both operands, both shift amounts, OpSel and mode.
- Buffers requests in a small FIFO and presents the head entry, already formatted, to the shifter's InA_Re/InA_Im/ShiftAmount_Re/ShiftAmount_Im/OpSel/mode inputs.
- Screens out non-shift opcodes so the shifter only ever sees SLL/SRL/SRA/ROL/ROR.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- DW, `DATA_WIDTH, operand width, taken from defines.v.
- SAW, $clog2(`DATA_WIDTH), shift-amount width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request present.
- in_ready  output  1  queue can accept a request this cycle.
- in_a_re  input  DW  real operand.
- in_a_im  input  DW  imaginary operand.
- in_sh_re  input  SAW  real shift amount.
- in_sh_im  input  SAW  imaginary shift amount.
- in_opsel  input  5  operation code (`SLL, `SRL, `SRA, `ROL, `ROR from defines.v).
- in_mode  input  1  0 = simple math, 1 = complex math.
- out_valid  output  1  head entry valid toward the shifter.
- out_ready  input  1  downstream consumed the head this cycle.
- out_a_re  output  DW  to InA_Re.
- out_a_im  output  DW  to InA_Im.
- out_sh_re  output  SAW  to ShiftAmount_Re.
- out_sh_im  output  SAW  to ShiftAmount_Im.
- out_opsel  output  5  to OpSel.
- out_mode  output  1  to mode.
- count  output  $clog2(DEPTH)+1  current occupancy.
- illegal_op  output  1  sticky flag: a non-shift opcode was dropped.

Behaviour:
- Clock/reset: one clock (clk). Reset is asynchronous, active-low (rst_n).
- Reset values: pointers=0, count=0, out_valid=0, illegal_op=0, in_ready=1. All out_* data ports =0. Storage contents are not reset.
- Accept: occurs when in_valid & in_ready on a rising edge. in_ready = (count < DEPTH), registered-free combinational from count.
- Opcode screen:
  - in_opsel matching none of the five shift codes: request is accepted (handshake completes) but not written.
  - illegal_op sets on that edge and stays set until reset.
- Complex-mode write rule: when in_mode=1, the entry stores sh_im = in_sh_re, so both lanes carry the same amount. Otherwise in_sh_im is stored unchanged.
- Pop: occurs when out_valid & out_ready. Head pointer advances and the next entry appears on the following cycle.
- Output data:
  - out_* are driven from the head storage entry.
  - When count=0, out_* are forced to 0 and out_opsel=0, so the shifter default branch yields 0.
- Latency: a request written into an empty queue shows out_valid=1 on the cycle after acceptance (1-cycle latency).
- Simultaneous push and pop:
  - Legal at any occupancy 1..DEPTH-1; count is unchanged.
  - At count=DEPTH, in_ready=0, so no push occurs even if a pop happens that cycle. There is no same-cycle full-through.
  - At count=0 there is no pop; the push proceeds.
- Wrap-around: read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. count distinguishes full from empty.
- Stability: out_* and out_valid hold stable while out_valid & ~out_ready.
- Reset mid-operation: all queued entries are discarded immediately (asynchronous) and out_valid drops in the same instant.

Optional Feature:
- Macro: SHIFT_QUEUE_BYPASS_EN.
- Defined:
  - When count=0 and in_valid with a legal opcode, the request is driven combinationally on out_* with out_valid=1 in the same cycle (0 latency).
  - If out_ready=1 that cycle, the entry is consumed and never written; count stays 0.
  - If out_ready=0, it is written normally.
- Undefined: fixed 1-cycle latency as above; no combinational in->out path.

Test Plan:
- Reset then single push: a_re=16'h8001, sh_re=3, opsel=`SRA, mode=0, out_ready=1.
  -> out_valid=1 the next cycle with the same values, then count returns to 0.
- Complex mode: push mode=1, sh_re=5, sh_im=2.
  -> out_sh_im=5, out_sh_re=5.
- Fill: push DEPTH=4 entries with out_ready=0.
  -> in_ready=0, count=4.
  -> A 5th push is ignored.
  -> Draining returns the entries in order 0,1,2,3 across a pointer wrap.
- Simultaneous push/pop at count=2 for 10 cycles.
  -> count stays 2, FIFO order is preserved, no data loss.
- Illegal opcode: push opsel=5'b11111.
  -> in_ready handshake completes, count unchanged, illegal_op=1 and stays 1 until rst_n.
- rst_n pulsed low asynchronously with 3 entries queued.
  -> out_valid=0 and count=0 before the next clk edge.
- With SHIFT_QUEUE_BYPASS_EN: empty queue, push with out_ready=1.
  -> out_valid=1 in the same cycle, count remains 0.
